// File: rtl/ultrasonido_disparo_pkg.sv
// -----------------------------------------------------------------------------
// ultrasonido_disparo_pkg
//   Shared definitions for the ultrasonic ranging block:
//   - estado_t      : ranging FSM state encoding (IDLE..HOLDOFF)
//   - DEF_CNT_W     : default width of every cycle counter and of echo_width
//   - DEF_*_CYCLES  : sensor timing constants for a 50 MHz clock
// -----------------------------------------------------------------------------
package ultrasonido_disparo_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } estado_t;

  localparam int DEF_CNT_W          = 22;
  localparam int DEF_TRIG_CYCLES    = 500;      // 10 us trigger pulse
  localparam int DEF_PERIOD_CYCLES  = 3000000;  // 60 ms between triggers
  localparam int DEF_TIMEOUT_CYCLES = 1500000;  // 30 ms echo wait / max width
  localparam int DEF_NEAR_CYCLES    = 29000;    // ~10 cm presence threshold
  localparam int DEF_FAR_CYCLES     = 34800;    // ~12 cm release threshold

endpackage : ultrasonido_disparo_pkg

// File: rtl/ultrasonido_disparo_sincronizador_flanco.sv
// -----------------------------------------------------------------------------
// sincronizador_flanco
//   Two-flop synchronizer for an asynchronous input followed by a registered
//   edge detector. Reusable by any sensor input path.
//
// Ports:
//   clk_i    in   system clock
//   rst_i    in   asynchronous active-high reset
//   async_i  in   raw asynchronous input
//   sync_o   out  synchronized level (second flop)
//   rise_o   out  one-cycle pulse on the first synchronized high cycle
//   fall_o   out  one-cycle pulse on the first synchronized low cycle
// -----------------------------------------------------------------------------
module sincronizador_flanco (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Edges are decoded purely from flops, so the pulses are glitch-free and
  // coincide with the first cycle the synchronized level has changed.
  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule : sincronizador_flanco

// File: rtl/ultrasonido_disparo.sv
// -----------------------------------------------------------------------------
// ultrasonido_disparo
//   Ultrasonic ranging controller: emits the periodic trigger pulse, times the
//   returning echo in clk cycles, and publishes a presence level derived from
//   the measured width.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   enable       in   level, 1 = keep ranging
//   echo_in      in   raw echo pin (asynchronous)
//   trig_out     out  trigger pin to the sensor (registered)
//   echo_width   out  last measured echo width in clk cycles
//   width_valid  out  one-cycle strobe when echo_width updates
//   presente     out  object-near level
//   timeout_err  out  one-cycle strobe on missing or over-long echo
//   state_dbg    out  current FSM state, for observation only
//
// Handshake: width_valid and timeout_err are single-cycle strobes with no
// back-pressure; a consumer must sample them on the cycle they are high.
// echo_width and presente are levels that hold until the next update.
//
// Configuration macro: ULTRA_HISTERESIS_EN
//   defined   : presente sets below NEAR_CYCLES, clears above FAR_CYCLES,
//               widths in between leave it unchanged.
//   undefined : presente = (width < NEAR_CYCLES); FAR_CYCLES is ignored.
// -----------------------------------------------------------------------------
module ultrasonido_disparo
  import ultrasonido_disparo_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int NEAR_CYCLES    = DEF_NEAR_CYCLES,
  parameter int FAR_CYCLES     = DEF_FAR_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             echo_in,
  output logic             trig_out,
  output logic [CNT_W-1:0] echo_width,
  output logic             width_valid,
  output logic             presente,
  output logic             timeout_err,
  output estado_t          state_dbg
);

  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST_C  = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_MAX_C = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_C       = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TOUT_LAST_C  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] NEAR_C       = CNT_W'(NEAR_CYCLES);

`ifdef ULTRA_HISTERESIS_EN
  localparam bit HYST_C = 1'b1;
`else
  localparam bit HYST_C = 1'b0;
`endif

  // Release threshold. Without hysteresis it collapses to NEAR-1, so the
  // "hold" band between set and release is empty and the rule reduces to
  // a single comparison against NEAR_CYCLES.
  localparam logic [CNT_W-1:0] REL_C =
    HYST_C ? CNT_W'(FAR_CYCLES) : CNT_W'(NEAR_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Echo synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic echo_s;
  logic echo_rise;
  logic echo_fall;

  sincronizador_flanco u_sync_echo (
    .clk_i   (clk),
    .rst_i   (reset),
    .async_i (echo_in),
    .sync_o  (echo_s),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  estado_t          state_q,    state_d;
  logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [CNT_W-1:0] period_q,   period_d;
  logic [CNT_W-1:0] tout_q,     tout_d;
  logic [CNT_W-1:0] width_q,    width_d;
  logic [CNT_W-1:0] echo_w_q,   echo_w_d;
  logic             trig_q,     trig_d;
  logic             valid_q,    valid_d;
  logic             terr_q,     terr_d;
  logic             pres_q,     pres_d;

  function automatic logic pres_next(input logic [CNT_W-1:0] w,
                                     input logic             cur);
    logic r;
    r = cur;
    if (w < NEAR_C) begin
      r = 1'b1;
    end else if (w > REL_C) begin
      r = 1'b0;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      trig_cnt_q <= '0;
      period_q   <= '0;
      tout_q     <= '0;
      width_q    <= '0;
      echo_w_q   <= '0;
      trig_q     <= 1'b0;
      valid_q    <= 1'b0;
      terr_q     <= 1'b0;
      pres_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      period_q   <= period_d;
      tout_q     <= tout_d;
      width_q    <= width_d;
      echo_w_q   <= echo_w_d;
      trig_q     <= trig_d;
      valid_q    <= valid_d;
      terr_q     <= terr_d;
      pres_q     <= pres_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    width_d    = width_q;
    echo_w_d   = echo_w_q;
    pres_d     = pres_q;
    valid_d    = 1'b0;
    terr_d     = 1'b0;

    // Free-running saturating counters; both are cleared on every TRIG entry,
    // so they measure time since the current trigger started.
    period_d = (period_q < PERIOD_MAX_C) ? period_q + ONE_C : period_q;
    tout_d   = (tout_q < TOUT_C) ? tout_q + ONE_C : tout_q;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = TRIG;
          period_d   = '0;
          tout_d     = '0;
          trig_cnt_d = '0;
        end
      end

      TRIG: begin
        trig_cnt_d = trig_cnt_q + ONE_C;
        if (trig_cnt_q >= TRIG_LAST_C) begin
          state_d = WAIT_RISE;
        end
      end

      WAIT_RISE: begin
        // Only a genuine low-to-high edge starts a measurement; a line that
        // was already high when the trigger ended never produces one here.
        if (echo_rise) begin
          state_d = MEASURE;
          width_d = ONE_C;
        end else if (tout_q >= TOUT_LAST_C) begin
          // Registered strobe lands exactly TIMEOUT_CYCLES after TRIG entry.
          state_d = HOLDOFF;
          terr_d  = 1'b1;
          pres_d  = 1'b0;
        end
      end

      MEASURE: begin
        if (echo_fall) begin
          state_d  = HOLDOFF;
          echo_w_d = width_q;
          valid_d  = 1'b1;
          pres_d   = pres_next(width_q, pres_q);
        end else if (width_q >= TOUT_C) begin
          state_d  = HOLDOFF;
          echo_w_d = TOUT_C;
          valid_d  = 1'b1;
          terr_d   = 1'b1;
          pres_d   = 1'b0;
        end else begin
          width_d = width_q + ONE_C;
        end
      end

      HOLDOFF: begin
        // Never re-trigger while the echo line is still high, even after the
        // period has elapsed, so a late echo cannot alias into the next shot.
        if ((period_q >= PERIOD_MAX_C) && !echo_s) begin
          if (enable) begin
            state_d    = TRIG;
            period_d   = '0;
            tout_d     = '0;
            trig_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered trigger: high for exactly the cycles spent in TRIG.
    trig_d = (state_d == TRIG);
  end

  assign trig_out    = trig_q;
  assign echo_width  = echo_w_q;
  assign width_valid = valid_q;
  assign presente    = pres_q;
  assign timeout_err = terr_q;
  assign state_dbg   = state_q;

endmodule : ultrasonido_disparo

// File: tb/tb_ultrasonido_disparo.sv
// -----------------------------------------------------------------------------
// tb_ultrasonido_disparo
//   Directed bench for ultrasonido_disparo with small timing parameters
//   (CNT_W=8, TRIG=5, PERIOD=200, TIMEOUT=100, NEAR=30, FAR=40).
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ultrasonido_disparo;
  import ultrasonido_disparo_pkg::*;

  localparam int CNT_W   = 8;
  localparam int TRIG_C  = 5;
  localparam int PER_C   = 200;
  localparam int TOUT_C  = 100;
  localparam int NEAR_C  = 30;
  localparam int FAR_C   = 40;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             echo_in;
  logic             trig_out;
  logic [CNT_W-1:0] echo_width;
  logic             width_valid;
  logic             presente;
  logic             timeout_err;
  estado_t          state_dbg;

  int errors;
  int checks;

  ultrasonido_disparo #(
    .CNT_W          (CNT_W),
    .TRIG_CYCLES    (TRIG_C),
    .PERIOD_CYCLES  (PER_C),
    .TIMEOUT_CYCLES (TOUT_C),
    .NEAR_CYCLES    (NEAR_C),
    .FAR_CYCLES     (FAR_C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .echo_in     (echo_in),
    .trig_out    (trig_out),
    .echo_width  (echo_width),
    .width_valid (width_valid),
    .presente    (presente),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver: one ranging cycle, starting at the negedge where trig_out is first
  // seen high (k=0). echo_in is high for k in [start, start+len). Returns when
  // the next trigger rises or after 400 cycles.
  // ---------------------------------------------------------------------------
  task automatic ranging(input int start, input int len, input int drop_en_at,
                         output int trig_len, output int nvalid,
                         output int nterr, output logic [CNT_W-1:0] w,
                         output int terr_k, output int same,
                         output int next_rise);
    int guard;
    bit fell;
    trig_len  = 0;
    nvalid    = 0;
    nterr     = 0;
    w         = '0;
    terr_k    = -1;
    same      = 0;
    next_rise = -1;
    fell      = 1'b0;
    guard     = 0;
    while (trig_out !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (trig_out !== 1'b1) begin
      errors++;
      $display("FAIL trig_start: trig_out=%b required 1", trig_out);
    end
    for (int k = 0; k < 400; k++) begin
      if (trig_out === 1'b1 && !fell) trig_len++;
      if (trig_out !== 1'b1) fell = 1'b1;
      else if (fell) begin
        next_rise = k;
        break;
      end
      if (width_valid === 1'b1) begin
        nvalid++;
        w = echo_width;
        if (timeout_err === 1'b1) same++;
      end
      if (timeout_err === 1'b1) begin
        nterr++;
        terr_k = k;
      end
      if (k == drop_en_at) enable = 1'b0;
      echo_in = (k >= start) && (k < start + len);
      @(negedge clk);
    end
    echo_in = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    echo_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({trig_out, width_valid, presente, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: trig,valid,pres,terr=%b required 0000",
               {trig_out, width_valid, presente, timeout_err});
    end
    checks++;
    if (echo_width !== 8'd0) begin
      errors++;
      $display("FAIL reset_width: echo_width=%0d required 0", echo_width);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d required %0d", state_dbg, IDLE);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (trig_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_trig: trig_out=%b required 0", trig_out);
    end
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (trig_out !== 1'b1) begin
      errors++;
      $display("FAIL enable_latency: trig_out=%b required 1 one cycle after enable",
               trig_out);
    end
  endtask

  task automatic test_near();
    int tl, nv, nt, tk, sm, nr;
    logic [CNT_W-1:0] w;
    ranging(15, 20, -1, tl, nv, nt, w, tk, sm, nr);
    checks++;
    if (tl !== TRIG_C) begin
      errors++;
      $display("FAIL near_trig_len: %0d cycles required %0d", tl, TRIG_C);
    end
    checks++;
    if (nv !== 1) begin
      errors++;
      $display("FAIL near_valid_count: %0d required 1", nv);
    end
    checks++;
    if (w < 8'd19 || w > 8'd21) begin
      errors++;
      $display("FAIL near_width: %0d required 20+-1", w);
    end
    checks++;
    if (presente !== 1'b1) begin
      errors++;
      $display("FAIL near_presente: %b required 1", presente);
    end
    checks++;
    if (nt !== 0) begin
      errors++;
      $display("FAIL near_timeout: %0d strobes required 0", nt);
    end
    checks++;
    if (nr !== PER_C) begin
      errors++;
      $display("FAIL near_period: next trig at %0d required %0d", nr, PER_C);
    end
  endtask

  task automatic test_no_echo();
    int tl, nv, nt, tk, sm, nr;
    logic [CNT_W-1:0] w;
    ranging(0, 0, -1, tl, nv, nt, w, tk, sm, nr);
    checks++;
    if (nt !== 1 || tk !== TOUT_C) begin
      errors++;
      $display("FAIL noecho_timeout: count=%0d at=%0d required 1 at %0d", nt, tk, TOUT_C);
    end
    checks++;
    if (nv !== 0) begin
      errors++;
      $display("FAIL noecho_valid: %0d required 0", nv);
    end
    checks++;
    if (presente !== 1'b0) begin
      errors++;
      $display("FAIL noecho_presente: %b required 0", presente);
    end
    checks++;
    if (nr !== PER_C) begin
      errors++;
      $display("FAIL noecho_period: next trig at %0d required %0d", nr, PER_C);
    end
  endtask

  task automatic test_far();
    int tl, nv, nt, tk, sm, nr;
    logic [CNT_W-1:0] w;
    ranging(15, 50, -1, tl, nv, nt, w, tk, sm, nr);
    checks++;
    if (nv !== 1 || w < 8'd49 || w > 8'd51) begin
      errors++;
      $display("FAIL far_width: valid=%0d width=%0d required 1 and 50+-1", nv, w);
    end
    checks++;
    if (presente !== 1'b0) begin
      errors++;
      $display("FAIL far_presente: %b required 0", presente);
    end
    checks++;
    if (nt !== 0) begin
      errors++;
      $display("FAIL far_timeout: %0d strobes required 0", nt);
    end
  endtask

  task automatic test_stuck();
    int tl, nv, nt, tk, sm, nr;
    logic [CNT_W-1:0] w;
    ranging(15, 150, -1, tl, nv, nt, w, tk, sm, nr);
    checks++;
    if (nv !== 1 || w !== 8'(TOUT_C)) begin
      errors++;
      $display("FAIL stuck_width: valid=%0d width=%0d required 1 and %0d", nv, w, TOUT_C);
    end
    checks++;
    if (sm !== 1 || nt !== 1) begin
      errors++;
      $display("FAIL stuck_same_cycle: together=%0d terr=%0d required 1 and 1", sm, nt);
    end
    checks++;
    if (presente !== 1'b0) begin
      errors++;
      $display("FAIL stuck_presente: %b required 0", presente);
    end
    checks++;
    if (nr !== PER_C) begin
      errors++;
      $display("FAIL stuck_period: next trig at %0d required %0d", nr, PER_C);
    end
  endtask

  // Echo already high when the trigger starts and held past the period.
  task automatic test_high_on_entry();
    int tl, nv, nt, tk, sm, nr;
    logic [CNT_W-1:0] w;
    ranging(0, 250, -1, tl, nv, nt, w, tk, sm, nr);
    checks++;
    if (nt !== 1 || tk !== TOUT_C) begin
      errors++;
      $display("FAIL highentry_timeout: count=%0d at=%0d required 1 at %0d", nt, tk, TOUT_C);
    end
    checks++;
    if (nv !== 0) begin
      errors++;
      $display("FAIL highentry_valid: %0d required 0", nv);
    end
    checks++;
    if (nr < 252 || nr > 254) begin
      errors++;
      $display("FAIL highentry_gate: next trig at %0d required 252..254", nr);
    end
  endtask

  task automatic test_hysteresis();
    int tl, nv, nt, tk, sm, nr;
    logic [CNT_W-1:0] w;
    int   widths [3];
    logic exp_p  [3];
    widths = '{25, 35, 45};
`ifdef ULTRA_HISTERESIS_EN
    exp_p = '{1'b1, 1'b1, 1'b0};
`else
    exp_p = '{1'b1, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 3; i++) begin
      ranging(15, widths[i], -1, tl, nv, nt, w, tk, sm, nr);
      checks++;
      if (nv !== 1 || int'(w) < widths[i] - 1 || int'(w) > widths[i] + 1) begin
        errors++;
        $display("FAIL hyst_width_%0d: valid=%0d width=%0d required 1 and %0d+-1",
                 i, nv, w, widths[i]);
      end
      checks++;
      if (presente !== exp_p[i]) begin
        errors++;
        $display("FAIL hyst_presente_%0d: %b required %b", i, presente, exp_p[i]);
      end
    end
  endtask

  task automatic test_reset_mid_measure();
    int tl, nv, nt, tk, sm, nr;
    int nvalid, ntrig, lat;
    logic [CNT_W-1:0] w;
    // A near measurement first so presente is high going into the reset.
    ranging(15, 20, -1, tl, nv, nt, w, tk, sm, nr);
    checks++;
    if (presente !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre_presente: %b required 1", presente);
    end
    for (int k = 0; k < 25; k++) begin
      echo_in = (k >= 15);
      @(negedge clk);
    end
    checks++;
    if (state_dbg !== MEASURE) begin
      errors++;
      $display("FAIL rstmid_in_measure: state=%0d required %0d", state_dbg, MEASURE);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({trig_out, presente, width_valid, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_outputs: trig,pres,valid,terr=%b required 0000",
               {trig_out, presente, width_valid, timeout_err});
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL rstmid_state: state=%0d required %0d", state_dbg, IDLE);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    nvalid = 0;
    ntrig  = 0;
    for (int k = 0; k < 300; k++) begin
      echo_in = (k < 8);
      if (width_valid === 1'b1) nvalid++;
      if (trig_out === 1'b1) ntrig++;
      @(negedge clk);
    end
    checks++;
    if (nvalid !== 0 || ntrig !== 0) begin
      errors++;
      $display("FAIL rstmid_quiet: valid=%0d trig=%0d required 0 and 0", nvalid, ntrig);
    end
    enable = 1'b1;
    lat    = -1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (trig_out === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL rstmid_restart: trig latency=%0d required 1", lat);
    end
  endtask

  task automatic test_enable_drop();
    int tl, nv, nt, tk, sm, nr;
    logic [CNT_W-1:0] w;
    ranging(15, 20, 20, tl, nv, nt, w, tk, sm, nr);
    checks++;
    if (nv !== 1 || w < 8'd19 || w > 8'd21) begin
      errors++;
      $display("FAIL endrop_width: valid=%0d width=%0d required 1 and 20+-1", nv, w);
    end
    checks++;
    if (presente !== 1'b1) begin
      errors++;
      $display("FAIL endrop_presente: %b required 1", presente);
    end
    checks++;
    if (nr !== -1) begin
      errors++;
      $display("FAIL endrop_no_retrigger: next trig at %0d required none", nr);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL endrop_state: state=%0d required %0d", state_dbg, IDLE);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    enable  = 1'b0;
    echo_in = 1'b0;
    test_reset();
    test_near();
    test_no_echo();
    test_near();
    test_far();
    test_stuck();
    test_high_on_entry();
    test_hysteresis();
    test_reset_mid_measure();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ultrasonido_disparo
